// File: rtl/systolic_drain.sv
// Bottom-edge result drain for an N x N output-stationary systolic array.
// Define SYSTOLIC_DRAIN_BOTTOM_FIRST_EN to stream rows bottom-first instead of top-first.
module systolic_drain #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N*DW-1:0] col_in,
    output logic            through,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [RW-1:0]   out_row,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(N - 1);

    state_t            state_q, state_d;
    logic [RW-1:0]     cap_q, cap_d;
    logic [RW-1:0]     snd_q, snd_d;
    logic [N*DW-1:0]   row_buf_q [N];
    logic [N*DW-1:0]   row_buf_d [N];
    logic              through_q, through_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [N*DW-1:0]   out_data_q, out_data_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic              done_q, done_d;
    logic [RW-1:0]     cap_idx;
    logic [RW-1:0]     send_idx;

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        snd_d       = snd_q;
        row_buf_d   = row_buf_q;
        through_d   = through_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        cap_idx     = LAST - cap_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DRAIN;
                    cap_d     = '0;
                    through_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            // The k-th drain cycle presents array row N-1-k at the bottom edge.
            S_DRAIN: begin
                row_buf_d[cap_idx] = col_in;
                cap_d              = cap_q + RW'(1);
                if (cap_q == LAST) begin
                    state_d     = S_SEND;
                    snd_d       = '0;
                    through_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (snd_q == LAST) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        snd_d = snd_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef SYSTOLIC_DRAIN_BOTTOM_FIRST_EN
        send_idx = LAST - snd_d;
`else
        send_idx = snd_d;
`endif

        // Look through the buffer's next value: row 0 lands on the same edge SEND begins.
        if (out_valid_d) begin
            out_data_d = row_buf_d[send_idx];
            out_row_d  = send_idx;
        end else begin
            out_data_d = '0;
            out_row_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            snd_q       <= '0;
            row_buf_q   <= '{default: '0};
            through_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            snd_q       <= snd_d;
            row_buf_q   <= row_buf_d;
            through_q   <= through_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            done_q      <= done_d;
        end
    end

    assign through   = through_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized self-checking bench for systolic_drain against a row-order reference model.
module tb_systolic_drain;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 2;
    localparam int W  = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  col_in;
    logic          through;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_row;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] rows [N];

    systolic_drain #(.N(N), .DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_in    (col_in),
        .through   (through),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_spec_rows;
        rows[3] = 32'h0D0C0B0A;
        rows[2] = 32'h09080706;
        rows[1] = 32'h05040302;
        rows[0] = 32'h01000F0E;
    endtask

    task automatic load_random_rows;
        for (int i = 0; i < N; i++) rows[i] = $urandom;
    endtask

    // One full drain: pulse start, feed rows bottom-up while through is high, consume beats.
    task automatic run_drain(input int stall_row, input int stall_len, input bit rand_ready,
                             input bit repulse, input string tag);
        logic [W-1:0] exp_data [$];
        int           exp_row  [$];
        int cyc, k, thr_cnt, first_thr, last_thr, beats, dones, stall_left, first_valid, r;
        bit rdy;
        exp_data.delete();
        exp_row.delete();
        for (int i = 0; i < N; i++) begin
`ifdef SYSTOLIC_DRAIN_BOTTOM_FIRST_EN
            r = N - 1 - i;
`else
            r = i;
`endif
            exp_row.push_back(r);
            exp_data.push_back(rows[r]);
        end
        cyc = 0; k = 0; thr_cnt = 0; first_thr = -1; last_thr = -1;
        beats = 0; dones = 0; stall_left = stall_len; first_valid = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (dones == 0 && cyc < 300) begin
            if (through) begin
                thr_cnt++;
                if (first_thr < 0) first_thr = cyc;
                last_thr = cyc;
                col_in = (k < N) ? rows[N-1-k] : W'($urandom);
                k++;
            end else begin
                col_in = W'($urandom);
            end
            start = repulse && (cyc == 1 || (out_valid && beats == 1));
            rdy = 1'b0;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                total++;
                if (beats >= N) begin
                    bad++;
                    $display("[TB] FAIL %s extra_beat: out_valid=1 after %0d beats, required 0", tag, beats);
                end else begin
                    if (out_row !== RW'(exp_row[beats])) begin
                        bad++;
                        $display("[TB] FAIL %s out_row beat%0d: got %0d want %0d", tag, beats, out_row, exp_row[beats]);
                    end
                    total++;
                    if (out_data !== exp_data[beats]) begin
                        bad++;
                        $display("[TB] FAIL %s out_data beat%0d: got %h want %h", tag, beats, out_data, exp_data[beats]);
                    end
                end
                if (stall_row == beats && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (rand_ready) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
                if (rdy) beats++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            out_ready = rdy;
            if (done) dones++;
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("[TB] FAIL %s done_count: got %0d want 1 (timeout)", tag, dones);
        end
        total++;
        if (beats != N) begin
            bad++;
            $display("[TB] FAIL %s beat_count: got %0d want %0d", tag, beats, N);
        end
        total++;
        if (thr_cnt != N || first_thr != 0 || last_thr - first_thr != N - 1) begin
            bad++;
            $display("[TB] FAIL %s through_window: cycles=%0d first=%0d last=%0d want %0d contiguous from 0", tag, thr_cnt, first_thr, last_thr, N);
        end
        total++;
        if (first_valid != N) begin
            bad++;
            $display("[TB] FAIL %s first_valid_cycle: got %0d want %0d", tag, first_valid, N);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || through !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s idle_after_done: done=%b busy=%b valid=%b through=%b want 0000", tag, done, busy, out_valid, through);
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; col_in = '0; out_ready = 1'b0;
        tick();
        total++;
        if ({through, busy, out_valid, done} !== 4'b0000 || out_data !== '0 || out_row !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: through=%b busy=%b valid=%b done=%b data=%h row=%0d want all 0", through, busy, out_valid, done, out_data, out_row);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        load_spec_rows();
        run_drain(-1, 0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_stall;
        load_spec_rows();
        run_drain(1, 5, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_back_to_back;
        load_spec_rows();
        run_drain(1, 2, 1'b0, 1'b1, "repulse");
    endtask

    task automatic test_random;
        for (int t = 0; t < 4; t++) begin
            load_random_rows();
            run_drain(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)), 1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_drain;
        start = 1'b1;
        tick();
        start = 1'b0;
        col_in = W'($urandom);
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (through !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_drain: through=%b busy=%b valid=%b want 000", through, busy, out_valid);
        end
        tick();
        reset = 1'b0;
        tick();
        load_random_rows();
        run_drain(-1, 0, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
